// File: rtl/arb_merge_pkg.sv
// Shared constants and helpers for the N-channel arbitrated merge.
`timescale 1ns/1ps
package arb_merge_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int MAX_CH    = 16;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = i + 1;
    end
    return r;
  endfunction

  // First requester at or above ptr, wrapping at n; returns a one-hot vector.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input logic [3:0] ptr,
                                                input int n);
    logic [MAX_CH-1:0] g;
    logic              found;
    int                idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (i < n) begin
        idx = int'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[3:0]]) begin
          g[idx[3:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/sync_fifo_ch.sv
// Per-channel circular buffer; storage is not reset, only pointers and count.
`timescale 1ns/1ps
module sync_fifo_ch
  import arb_merge_pkg::*;
#(
  parameter  int DEPTH      = 2,
  parameter  int DATA_WIDTH = 6,
  localparam int AW         = clog2_f(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_head,
  output logic [CW-1:0]         o_count
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/arb_merge_n_sync.sv
// N-channel buffered merge with fixed-priority or round-robin arbitration
// feeding a registered, channel-tagged valid/ready output slot.
`timescale 1ns/1ps
module arb_merge_n_sync
  import arb_merge_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 6,
  parameter  int DEPTH      = 2,
  parameter  int RR_MODE    = 1,
  localparam int CH_W       = clog2_f(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            i_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
  output logic [NUM_CH-1:0]            o_ready,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [CH_W-1:0]              o_ch_id,
  input  logic                         i_ready,
  output logic [NUM_CH-1:0]            o_grant
);

  localparam int CNT_W = clog2_f(DEPTH) + 1;

  logic [NUM_CH-1:0]     w_push;
  logic [NUM_CH-1:0]     w_pop;
  logic [NUM_CH-1:0]     w_full;
  logic [NUM_CH-1:0]     w_empty;
  logic [NUM_CH-1:0]     w_req;
  logic [NUM_CH-1:0]     w_grant;
  logic [NUM_CH-1:0]     w_grant_fp;
  logic [NUM_CH-1:0]     w_grant_rr;
  logic [MAX_CH-1:0]     w_rr_full;
  logic [DATA_WIDTH-1:0] w_head  [NUM_CH];
  logic [CNT_W-1:0]      w_count [NUM_CH];
  logic [CH_W-1:0]       w_gidx;
  logic [CH_W-1:0]       w_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_gdata;
  logic                  w_load;

  logic [CH_W-1:0]       r_ptr;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CH_W-1:0]       r_ch_id;
  logic [NUM_CH-1:0]     r_grant;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    sync_fifo_ch #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (w_push[k]),
      .i_pop   (w_pop[k]),
      .i_data  (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_full  (w_full[k]),
      .o_empty (w_empty[k]),
      .o_head  (w_head[k]),
      .o_count (w_count[k])
    );

    assign o_ready[k] = ~w_full[k];
    assign w_push[k]  = i_valid[k] & ~w_full[k];
    assign w_req[k]   = ~w_empty[k];
    assign w_pop[k]   = w_load & w_grant[k];

    a_count_ok: assert property (@(posedge clk) disable iff (!rstn)
      (w_count[k] <= CNT_W'(DEPTH)) && (w_empty[k] == (w_count[k] == '0)));
  end

  assign w_load     = (|w_req) & (~r_valid | i_ready);
  assign w_grant_fp = w_req & (~w_req + 1'b1);
  assign w_rr_full  = rr_pick(MAX_CH'(w_req), 4'(r_ptr), NUM_CH);
  assign w_grant_rr = w_rr_full[NUM_CH-1:0];
  assign w_grant    = (RR_MODE == ARB_RR) ? w_grant_rr : w_grant_fp;

  // Grant is one-hot, so the last match is the only match.
  always_comb begin
    w_gidx  = '0;
    w_gdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grant[k]) begin
        w_gidx  = CH_W'(k);
        w_gdata = w_head[k];
      end
    end
  end

  assign w_ptr_nxt = (w_gidx == CH_W'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch_id <= '0;
      r_grant <= '0;
    end else if (w_load) begin
      r_ptr   <= w_ptr_nxt;
      r_valid <= 1'b1;
      r_data  <= w_gdata;
      r_ch_id <= w_gidx;
      r_grant <= w_grant;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ch_id = r_ch_id;
  assign o_grant = r_grant;

endmodule

// File: tb/tb_arb_merge_n_sync.sv
// Directed bench: one round-robin and one fixed-priority instance, hand-computed expectations.
`timescale 1ns/1ps
module tb_arb_merge_n_sync;

  localparam int NUM_CH = 4;
  localparam int DW     = 6;
  localparam int DEPTH  = 2;
  localparam int CH_W   = 2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]    iv_rr, iv_fp, or_rr, or_fp, og_rr, og_fp;
  logic [NUM_CH*DW-1:0] id_rr, id_fp;
  logic                 ir_rr, ir_fp, ov_rr, ov_fp;
  logic [DW-1:0]        od_rr, od_fp;
  logic [CH_W-1:0]      oc_rr, oc_fp;

  arb_merge_n_sync #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RR_MODE(1)) u_rr (
    .clk(clk), .rstn(rstn), .i_valid(iv_rr), .i_data(id_rr), .o_ready(or_rr),
    .o_valid(ov_rr), .o_data(od_rr), .o_ch_id(oc_rr), .i_ready(ir_rr), .o_grant(og_rr));

  arb_merge_n_sync #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RR_MODE(0)) u_fp (
    .clk(clk), .rstn(rstn), .i_valid(iv_fp), .i_data(id_fp), .o_ready(or_fp),
    .o_valid(ov_fp), .o_data(od_fp), .o_ch_id(oc_fp), .i_ready(ir_fp), .o_grant(og_fp));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn  = 1'b0;
    iv_rr = '0; iv_fp = '0; id_rr = '0; id_fp = '0;
    repeat (3) tick;
    rstn = 1'b1;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NUM_CH-1:0] acc;
    int seq [NUM_CH];
    int oseq [NUM_CH];
    int exp_ch, n_out, s0, s3;
    logic [DW-1:0] exp_d [9];
    logic [CH_W-1:0] exp_c [9];

    ir_rr = 1'b1; ir_fp = 1'b1;
    do_reset;

    // Reset state
    chk("rst_valid_rr", ov_rr, 0);
    chk("rst_data_rr",  od_rr, 0);
    chk("rst_chid_rr",  oc_rr, 0);
    chk("rst_grant_rr", og_rr, 0);
    chk("rst_ready_rr", or_rr, 4'b1111);
    chk("rst_valid_fp", ov_fp, 0);
    chk("rst_ready_fp", or_fp, 4'b1111);

    // Single word latency on ch2
    tick;
    iv_rr = 4'b0100;
    id_rr = '0;
    id_rr[2*DW +: DW] = 6'h2A;
    tick;
    iv_rr = '0;
    chk("lat_n1_valid", ov_rr, 0);
    tick;
    chk("lat_n2_valid", ov_rr, 1);
    chk("lat_n2_data",  od_rr, 6'h2A);
    chk("lat_n2_chid",  oc_rr, 2);
    chk("lat_n2_grant", og_rr, 4'b0100);
    tick;
    chk("lat_n3_valid", ov_rr, 0);
    chk("lat_n3_grant_held", og_rr, 4'b0100);
    chk("lat_n3_data_held",  od_rr, 6'h2A);

    // Backpressure: ch1 pushes 1..4 with i_ready low
    ir_rr = 1'b0;
    for (int w = 1; w <= 3; w++) begin
      chk("bp_ready_before_push", or_rr[1], 1);
      iv_rr = 4'b0010;
      id_rr = '0;
      id_rr[1*DW +: DW] = DW'(w);
      tick;
    end
    iv_rr = 4'b0010;
    id_rr = '0;
    id_rr[1*DW +: DW] = 6'd4;
    chk("bp_full_ready", or_rr, 4'b1101);
    chk("bp_slot_valid", ov_rr, 1);
    chk("bp_slot_data",  od_rr, 1);
    chk("bp_slot_chid",  oc_rr, 1);
    repeat (2) tick;
    chk("bp_stall_ready", or_rr[1], 0);
    chk("bp_hold_data",   od_rr, 1);
    chk("bp_hold_valid",  ov_rr, 1);
    ir_rr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      acc = iv_rr & or_rr;
      tick;
      if (acc[1]) iv_rr = '0;
      chk("bp_drain_valid", ov_rr, 1);
      chk("bp_drain_data",  od_rr, DW'(i + 2));
    end
    tick;
    chk("bp_drain_done", ov_rr, 0);
    chk("bp_all_ready",  or_rr, 4'b1111);

    // Round-robin fairness, all channels saturating
    do_reset;
    ir_rr = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin seq[k] = 0; oseq[k] = 0; end
    exp_ch = 0;
    n_out  = 0;
    for (int i = 0; i < 20; i++) begin
      iv_rr = '1;
      for (int k = 0; k < NUM_CH; k++) id_rr[k*DW +: DW] = DW'(k*8 + seq[k] % 8);
      acc = iv_rr & or_rr;
      tick;
      for (int k = 0; k < NUM_CH; k++) if (acc[k]) seq[k]++;
      if (i == 0) chk("rr_first_not_early", ov_rr, 0);
      if (ov_rr) begin
        n_out++;
        chk("rr_chid", oc_rr, exp_ch);
        chk("rr_data", od_rr, exp_ch*8 + oseq[exp_ch] % 8);
        oseq[exp_ch]++;
        exp_ch = (exp_ch + 1) % NUM_CH;
      end
    end
    chk("rr_throughput", n_out, 19);
    iv_rr = '0;

    // Fixed priority: ch0 sends 5 words, ch3 saturates
    exp_d = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd24, 6'd25, 6'd26, 6'd27};
    exp_c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3};
    ir_fp = 1'b1;
    s0 = 0; s3 = 0; n_out = 0;
    for (int i = 0; i < 10; i++) begin
      iv_fp = '0;
      id_fp = '0;
      iv_fp[0] = (s0 < 5);
      iv_fp[3] = 1'b1;
      id_fp[0*DW +: DW] = DW'(s0);
      id_fp[3*DW +: DW] = DW'(24 + s3);
      acc = iv_fp & or_fp;
      tick;
      if (acc[0]) s0++;
      if (acc[3]) s3++;
      if (i == 0) begin
        chk("fp_first_not_early", ov_fp, 0);
      end else begin
        chk("fp_valid", ov_fp, 1);
        chk("fp_chid",  oc_fp, exp_c[i-1]);
        chk("fp_data",  od_fp, exp_d[i-1]);
      end
    end
    iv_fp = '0;

    // Asynchronous reset with buffered words and a full slot
    do_reset;
    ir_rr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv_rr = 4'b0011;
      id_rr = '0;
      id_rr[0*DW +: DW] = DW'(5 + i);
      id_rr[1*DW +: DW] = DW'(9 + i);
      tick;
    end
    iv_rr = '0;
    chk("ar_pre_valid", ov_rr, 1);
    chk("ar_pre_ready", or_rr, 4'b1101);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_valid_clr", ov_rr, 0);
    chk("ar_ready_set", or_rr, 4'b1111);
    chk("ar_data_clr",  od_rr, 0);
    chk("ar_grant_clr", og_rr, 0);
    #2;
    rstn  = 1'b1;
    ir_rr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("ar_no_stale", ov_rr, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arb_merge_n_sync.md
Name: arb_merge_n_sync

Overview:
- Clocked, parametrised successor to the two-input drive/free arbitrated merge used on the cache control path.
- Merges NUM_CH independent producer channels into one consumer stream.
- Each channel has a DEPTH-entry buffer. Arbitration is fixed-priority or round-robin, and the output stage is a registered valid/ready slot tagged with the source channel index.
- Sits between cache request sources (miss/refill/writeback queues) and a single downstream port.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_WIDTH, 6, payload width per channel.
- DEPTH, 2, per-channel buffer depth (power of 2, >=2).
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
- CH_W, $clog2(NUM_CH), width of the channel tag (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- i_valid  in  NUM_CH  per-channel data present.
- i_data  in  NUM_CH*DATA_WIDTH  packed payloads; channel k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- o_ready  out  NUM_CH  per-channel buffer not full.
- o_valid  out  1  output slot holds a word.
- o_data  out  DATA_WIDTH  output payload.
- o_ch_id  out  CH_W  source channel of o_data.
- i_ready  in  1  consumer accepts o_data this cycle.
- o_grant  out  NUM_CH  one-hot channel granted on the last output-slot load; all zero if none.

Behaviour:
- Reset:
  - All buffers empty; o_ready = all ones (after reset deassertion).
  - o_valid = 0, o_data = 0, o_ch_id = 0, o_grant = 0.
  - Round-robin pointer = 0.
- Input handshake: word k is accepted at a rising edge when i_valid[k] & o_ready[k].
  - o_ready[k] = (count[k] != DEPTH) and depends only on registered state.
  - No same-cycle pass-through when full: a pop in the same cycle does not raise o_ready that cycle.
- Buffers:
  - Circular, with a write pointer, read pointer and a count of width $clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop on the same channel leaves count unchanged.
- Request vector: req[k] = (count[k] != 0).
- Load condition: load = (|req) & (~o_valid | i_ready).
- Grant:
  - RR_MODE = 0: grant = req & (~req + 1), i.e. the lowest set bit.
  - RR_MODE = 1: first set bit of req searched from index ptr upward, wrapping.
  - On load: ptr <= granted index + 1, mod NUM_CH. Without load, ptr is held.
  - The grant is combinational. The granted buffer is popped and the output slot loaded on the same edge.
- Output slot:
  - On load: o_valid <= 1, o_data <= head of the granted buffer, o_ch_id <= granted index, o_grant <= grant.
  - On o_valid & i_ready without load: o_valid <= 0, and o_data/o_ch_id/o_grant are held.
  - o_data must not change while o_valid & ~i_ready.
- Latency:
  - A word presented and accepted in cycle n appears on o_valid in cycle n+2 at the earliest.
  - Sustained throughput is 1 word/cycle when i_ready = 1.
- Fairness: under RR_MODE = 1 with all channels continuously requesting, each channel is granted exactly once per NUM_CH loads.
- Backpressure: with i_ready = 0, the slot holds and buffers fill. Each o_ready[k] drops after DEPTH accepted words, with no loss or duplication.
- Reset mid-operation: asserting rstn low immediately (asynchronously) empties all buffers and clears outputs. Buffered words are discarded.
- Ordering: per-channel FIFO order is preserved. There is no cross-channel ordering guarantee.

Decomposition:
- Shared package arb_merge_pkg holds:
  - localparams ARB_FIXED = 0 and ARB_RR = 1;
  - function clog2_f;
  - function rr_pick(req, ptr), returning a one-hot grant.
- One natural sub-module: sync_fifo_ch (DEPTH, DATA_WIDTH), instantiated NUM_CH times via generate. It exposes push, pop, full, empty, head and count.
- Arbiter, output slot and pointer logic live in the top.

Test Plan:
- Reset check:
  - Stimulus: hold rstn = 0 for 3 cycles, then release.
  - Required: o_valid = 0, o_data = 0, o_ch_id = 0, o_grant = 0, o_ready = 4'b1111.
- Single word latency:
  - Stimulus: ch2 presents 6'h2A in cycle 5, i_ready = 1.
  - Required: o_valid = 1 in cycle 7 with o_data = 6'h2A, o_ch_id = 2, o_grant = 4'b0100. o_valid = 0 in cycle 8.
- Round-robin fairness:
  - Stimulus: RR_MODE = 1, all 4 channels continuously push (ch k sends k*8+seq), i_ready = 1.
  - Required: o_ch_id sequence is 0,1,2,3,0,1,2,3…, and per-channel data is in order.
- Fixed priority starvation:
  - Stimulus: RR_MODE = 0, ch0 and ch3 both saturate.
  - Required: only ch0 is output until ch0 stops. ch3's first word appears 1 cycle after ch0's buffer empties.
- Backpressure/full:
  - Stimulus: i_ready = 0, ch1 pushes 4 words (1,2,3,4).
  - Required: the slot holds 1. Words 2,3 fill the buffer. o_ready[1] = 0 from the cycle after word 3 is accepted, so word 4 is stalled.
  - Then raise i_ready = 1. Required: outputs 1,2,3,4 in consecutive cycles, with no drop or duplicate.
- Async reset mid-stream:
  - Stimulus: pull rstn low between clock edges while buffers are half full and o_valid = 1.
  - Required: o_valid = 0 and o_ready = all ones without waiting for a clock edge. No stale word emerges after release.
